// File: rtl/pad_gpio_pkg.sv
// pad_gpio_pkg: register indices and bus width shared by the GPIO controller files
package pad_gpio_pkg;
    localparam int DATA_W = 32;
    localparam logic [2:0] GPIO_OUT_IDX    = 3'd0;
    localparam logic [2:0] GPIO_OE_IDX     = 3'd1;
    localparam logic [2:0] GPIO_IN_IDX     = 3'd2;
    localparam logic [2:0] GPIO_IEN_IDX    = 3'd3;
    localparam logic [2:0] GPIO_RISE_IDX   = 3'd4;
    localparam logic [2:0] GPIO_FALL_IDX   = 3'd5;
    localparam logic [2:0] GPIO_PEND_IDX   = 3'd6;
    localparam logic [2:0] GPIO_DEBTHR_IDX = 3'd7;
endpackage

// File: rtl/pad_gpio_ctrl_if.sv
// pad_gpio_ctrl_if: peripheral register bus between the SoC and the GPIO controller
interface pad_gpio_ctrl_if;
    import pad_gpio_pkg::*;
    logic              reg_wr_i;
    logic [2:0]        reg_addr_i;
    logic [DATA_W-1:0] reg_wdata_i;
    logic [DATA_W-1:0] reg_rdata_o;
    modport master (output reg_wr_i, reg_addr_i, reg_wdata_i, input reg_rdata_o);
    modport slave  (input reg_wr_i, reg_addr_i, reg_wdata_i, output reg_rdata_o);
endinterface

// File: rtl/pad_gpio_deb.sv
// pad_gpio_deb: per-pin synchroniser, debounce filter and edge events for one pad input
module pad_gpio_deb #(
    parameter int DEB_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             p2c_i,
    input  logic [DEB_W-1:0] thr_i,
    output logic             stable_o,
    output logic             rise_o,
    output logic             fall_o
);
    logic             s1_q, s2_q, stable_q, stable_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic [DEB_W:0]   cnt_inc, thr_eff;
    logic             diff, commit;
    // A threshold of 0 behaves as 1; the extra bit keeps cnt+1 from wrapping before commit
    always_comb begin
        thr_eff  = (thr_i == '0) ? (DEB_W+1)'(1) : {1'b0, thr_i};
        cnt_inc  = {1'b0, cnt_q} + (DEB_W+1)'(1);
        diff     = s2_q ^ stable_q;
        commit   = diff && (cnt_inc >= thr_eff);
        stable_d = commit ? s2_q : stable_q;
        cnt_d    = (!diff || commit) ? '0 : cnt_inc[DEB_W-1:0];
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= p2c_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end
    assign stable_o = stable_q;
    assign rise_o   = commit & s2_q & ~stable_q;
    assign fall_o   = commit & ~s2_q & stable_q;
endmodule

// File: rtl/pad_gpio_ctrl.sv
// pad_gpio_ctrl: GPIO register file driving tri-state pads, with debounced inputs and edge interrupts
module pad_gpio_ctrl
    import pad_gpio_pkg::*;
#(
    parameter int GPIO_NUM = 8,
    parameter int DEB_W    = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    pad_gpio_ctrl_if.slave      bus,
    output logic [GPIO_NUM-1:0] gpio_c2p_o,
    output logic [GPIO_NUM-1:0] gpio_c2p_en_o,
    input  logic [GPIO_NUM-1:0] gpio_p2c_i,
    output logic                irq_o
);
    logic [GPIO_NUM-1:0] out_q, out_d, oe_q, oe_d, ien_q, ien_d;
    logic [GPIO_NUM-1:0] rise_q, rise_d, fall_q, fall_d, pend_q, pend_d;
    logic [DEB_W-1:0]    debthr_q, debthr_d;
    logic [GPIO_NUM-1:0] in_w, rise_ev, fall_ev, wd;
    logic [7:0]          sel;
    logic [DATA_W-1:0]   rdata;
    for (genvar i = 0; i < GPIO_NUM; i++) begin : g_pin
        pad_gpio_deb #(.DEB_W(DEB_W)) u_deb (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .p2c_i    (gpio_p2c_i[i]),
            .thr_i    (debthr_q),
            .stable_o (in_w[i]),
            .rise_o   (rise_ev[i]),
            .fall_o   (fall_ev[i])
        );
    end
    // Set term is OR-ed after the W1C mask so a simultaneous event wins over the clear
    always_comb begin
        wd       = bus.reg_wdata_i[GPIO_NUM-1:0];
        sel      = bus.reg_wr_i ? (8'd1 << bus.reg_addr_i) : 8'd0;
        out_d    = sel[GPIO_OUT_IDX]  ? wd : out_q;
        oe_d     = sel[GPIO_OE_IDX]   ? wd : oe_q;
        ien_d    = sel[GPIO_IEN_IDX]  ? wd : ien_q;
        rise_d   = sel[GPIO_RISE_IDX] ? wd : rise_q;
        fall_d   = sel[GPIO_FALL_IDX] ? wd : fall_q;
        pend_d   = (pend_q & ~(sel[GPIO_PEND_IDX] ? wd : '0)) | (rise_ev & rise_q) | (fall_ev & fall_q);
        debthr_d = sel[GPIO_DEBTHR_IDX] ? bus.reg_wdata_i[DEB_W-1:0] : debthr_q;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q    <= '0;
            oe_q     <= '0;
            ien_q    <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            pend_q   <= '0;
            debthr_q <= '0;
        end else begin
            out_q    <= out_d;
            oe_q     <= oe_d;
            ien_q    <= ien_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            pend_q   <= pend_d;
            debthr_q <= debthr_d;
        end
    end
    always_comb begin
        rdata = '0;
        case (bus.reg_addr_i)
            GPIO_OUT_IDX:    rdata[GPIO_NUM-1:0] = out_q;
            GPIO_OE_IDX:     rdata[GPIO_NUM-1:0] = oe_q;
            GPIO_IN_IDX:     rdata[GPIO_NUM-1:0] = in_w;
            GPIO_IEN_IDX:    rdata[GPIO_NUM-1:0] = ien_q;
            GPIO_RISE_IDX:   rdata[GPIO_NUM-1:0] = rise_q;
            GPIO_FALL_IDX:   rdata[GPIO_NUM-1:0] = fall_q;
            GPIO_PEND_IDX:   rdata[GPIO_NUM-1:0] = pend_q;
            GPIO_DEBTHR_IDX: rdata[DEB_W-1:0]    = debthr_q;
        endcase
    end
    assign bus.reg_rdata_o = rdata;
    assign gpio_c2p_o      = out_q;
    assign gpio_c2p_en_o   = oe_q;
    assign irq_o           = |(pend_q & ien_q);
endmodule

// File: tb/tb_pad_gpio_ctrl.sv
// tb_pad_gpio_ctrl: directed register, debounce, edge-interrupt and reset checks for pad_gpio_ctrl
module tb_pad_gpio_ctrl;
    import pad_gpio_pkg::*;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] p2c = 8'h00;
    logic [7:0] c2p, c2p_en;
    logic       irq;
    int         checks = 0;
    int         failures = 0;
    pad_gpio_ctrl_if bus ();
    pad_gpio_ctrl #(.GPIO_NUM(8), .DEB_W(8)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .bus           (bus),
        .gpio_c2p_o    (c2p),
        .gpio_c2p_en_o (c2p_en),
        .gpio_p2c_i    (p2c),
        .irq_o         (irq)
    );
    always #10 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.reg_wr_i    = 1'b1;
        bus.reg_addr_i  = a;
        bus.reg_wdata_i = d;
        tick(1);
        bus.reg_wr_i    = 1'b0;
    endtask
    task automatic rd(input logic [2:0] a, input string tag, input logic [31:0] exp);
        bus.reg_addr_i = a;
        #1;
        check(tag, bus.reg_rdata_o, exp);
    endtask
    initial begin
        bus.reg_wr_i    = 1'b0;
        bus.reg_addr_i  = 3'd0;
        bus.reg_wdata_i = 32'h0;
        tick(3);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) rd(i[2:0], "reset_reg", 32'h0);
        check("reset_c2p", {24'h0, c2p}, 32'h0);
        check("reset_c2p_en", {24'h0, c2p_en}, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        wr(GPIO_OUT_IDX, 32'hA5);
        wr(GPIO_OE_IDX, 32'h0F);
        check("c2p", {24'h0, c2p}, 32'hA5);
        check("c2p_en", {24'h0, c2p_en}, 32'h0F);
        wr(GPIO_IN_IDX, 32'hFF);
        rd(GPIO_IN_IDX, "in_readonly", 32'h0);
        rd(GPIO_OUT_IDX, "out_readback", 32'hA5);
        // Threshold 0: visible after exactly 3 edges
        p2c = 8'h01;
        tick(2);
        rd(GPIO_IN_IDX, "thr0_edge2", 32'h0);
        tick(1);
        rd(GPIO_IN_IDX, "thr0_edge3", 32'h1);
        p2c = 8'h00;
        tick(3);
        rd(GPIO_IN_IDX, "thr0_fall", 32'h0);
        wr(GPIO_DEBTHR_IDX, 32'd4);
        p2c = 8'h01;
        tick(5);
        rd(GPIO_IN_IDX, "thr4_edge5", 32'h0);
        tick(1);
        rd(GPIO_IN_IDX, "thr4_edge6", 32'h1);
        p2c = 8'h00;
        tick(6);
        rd(GPIO_IN_IDX, "thr4_fall", 32'h0);
        wr(GPIO_RISE_IDX, 32'h01);
        p2c = 8'h01;
        tick(3);
        p2c = 8'h00;
        tick(10);
        rd(GPIO_IN_IDX, "glitch_in", 32'h0);
        rd(GPIO_PEND_IDX, "glitch_pend", 32'h0);
        wr(GPIO_IEN_IDX, 32'h01);
        p2c = 8'h01;
        tick(5);
        rd(GPIO_PEND_IDX, "pend_before", 32'h0);
        check("irq_before", {31'h0, irq}, 32'h0);
        tick(1);
        rd(GPIO_PEND_IDX, "pend_commit", 32'h1);
        check("irq_commit", {31'h0, irq}, 32'h1);
        wr(GPIO_PEND_IDX, 32'h01);
        rd(GPIO_PEND_IDX, "pend_w1c", 32'h0);
        check("irq_w1c", {31'h0, irq}, 32'h0);
        wr(GPIO_FALL_IDX, 32'h00);
        p2c = 8'h00;
        tick(8);
        rd(GPIO_IN_IDX, "fall_in", 32'h0);
        rd(GPIO_PEND_IDX, "fall_disabled", 32'h0);
        check("irq_fall", {31'h0, irq}, 32'h0);
        // Clear write lands on the commit edge; the set must win
        wr(GPIO_IEN_IDX, 32'h00);
        p2c = 8'h01;
        tick(5);
        wr(GPIO_PEND_IDX, 32'h01);
        rd(GPIO_PEND_IDX, "set_wins", 32'h1);
        check("irq_ien_off", {31'h0, irq}, 32'h0);
        wr(GPIO_IEN_IDX, 32'h01);
        check("irq_ien_on", {31'h0, irq}, 32'h1);
        wr(GPIO_PEND_IDX, 32'h01);
        rd(GPIO_PEND_IDX, "pend_clear2", 32'h0);
        p2c = 8'h00;
        tick(8);
        wr(GPIO_RISE_IDX, 32'h08);
        wr(GPIO_IEN_IDX, 32'h08);
        wr(GPIO_DEBTHR_IDX, 32'd200);
        rd(GPIO_DEBTHR_IDX, "debthr_rb", 32'd200);
        p2c = 8'h08;
        tick(50);
        rd(GPIO_IN_IDX, "thr200_hold", 32'h0);
        wr(GPIO_DEBTHR_IDX, 32'd10);
        rd(GPIO_IN_IDX, "thr_lower_wr", 32'h0);
        tick(1);
        rd(GPIO_IN_IDX, "thr_lower_commit", 32'h08);
        rd(GPIO_PEND_IDX, "pend_pin3", 32'h08);
        check("irq_pin3", {31'h0, irq}, 32'h1);
        p2c = 8'h00;
        tick(4);
        rst = 1'b1;
        #2;
        check("async_c2p", {24'h0, c2p}, 32'h0);
        check("async_c2p_en", {24'h0, c2p_en}, 32'h0);
        check("async_irq", {31'h0, irq}, 32'h0);
        rd(GPIO_IN_IDX, "async_in", 32'h0);
        rd(GPIO_PEND_IDX, "async_pend", 32'h0);
        rd(GPIO_DEBTHR_IDX, "async_debthr", 32'h0);
        tick(2);
        rst = 1'b0;
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pad_gpio_ctrl.md
Name: pad_gpio_ctrl

Overview:
- Per-pin GPIO controller directly upstream/downstream of the tri-state IO pad cells.
- Drives each pad's c2p/c2p_en from software registers and consumes p2c.
- Synchronises, debounces and edge-detects p2c, and raises a level interrupt to the SoC.
- Sits between the peripheral register bus and a bank of GPIO_NUM tri-state pads.

Parameters:
- GPIO_NUM, 8, number of pins (1..32)
- DEB_W, 8, debounce counter/threshold width (1..16)

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous, active-high reset
- reg_wr_i  in  1  single-cycle write strobe
- reg_addr_i  in  3  register index
- reg_wdata_i  in  32  write data
- reg_rdata_o  out  32  read data, combinational from reg_addr_i
- gpio_c2p_o  out  GPIO_NUM  pad output data
- gpio_c2p_en_o  out  GPIO_NUM  pad output enable (1 = drive)
- gpio_p2c_i  in  GPIO_NUM  raw pad input, asynchronous
- irq_o  out  1  level interrupt

Behaviour:
- Register map (index: name, access; bits [GPIO_NUM-1:0] unless noted):
  - 0: OUT, RW
  - 1: OE, RW
  - 2: IN, RO, debounced value
  - 3: IEN, RW
  - 4: RISE, RW, rising-edge enable
  - 5: FALL, RW, falling-edge enable
  - 6: PEND, RW1C
  - 7: DEBTHR, RW, bits [DEB_W-1:0]
- Unused upper bits read 0. Writes to IN are ignored. Register writes take effect on the clock edge where reg_wr_i=1.
- Reset values: all registers 0, gpio_c2p_o=0, gpio_c2p_en_o=0 (all pads input), irq_o=0, sync/stable flops 0, counters 0.
- Pad outputs: gpio_c2p_o = OUT, gpio_c2p_en_o = OE, both direct from flops. No combinational path from the bus.
- Input path per pin:
  - 2-flop synchroniser s1 -> s2, then a stable flop.
  - Counter cnt[DEB_W-1:0].
  - If s2 == stable: cnt <= 0.
  - Else if cnt + 1 >= max(DEBTHR, 1): stable <= s2, cnt <= 0.
  - Else: cnt <= cnt + 1.
  - DEBTHR = 0 or 1 means no filtering.
  - Latency from a p2c change to IN visible: 2 + max(DEBTHR, 1) clock edges.
  - A glitch shorter than DEBTHR cycles at s2 never reaches stable.
- Threshold changes mid-count:
  - Compare uses >=, so lowering DEBTHR below the current cnt commits on the next differing cycle.
  - The counter never wraps: it saturates by construction.
- Edge detect:
  - rise_ev = commit & s2 & ~stable; fall_ev = commit & ~s2 & stable.
  - PEND[i] is set on the same edge stable changes, if (rise_ev & RISE[i]) | (fall_ev & FALL[i]).
  - PEND sets independently of IEN.
- PEND write: bits written 1 clear. If a set and a clear hit the same bit in the same cycle, set wins.
- irq_o = |(PEND & IEN), combinational from flops. Enabling IEN on an already-pending bit asserts irq_o in the same cycle the IEN flop updates.
- Toggling OE or OUT has no effect on the input path beyond what the pad returns.
- Reset asserted mid-debounce discards cnt and the pending state immediately (asynchronous).

Decomposition:
- Shared package pad_gpio_pkg holds:
  - Register index constants GPIO_OUT_IDX..GPIO_DEBTHR_IDX (3-bit).
  - Data width 32.
- One sub-module pad_gpio_deb (synchroniser, debounce counter, stable flop, rise/fall event outputs; parameter DEB_W; threshold input) is instantiated GPIO_NUM times in a generate loop.
- Register file, PEND logic and read mux live in the top.

Test Plan:
- Reset, then read all 8 indices -> all 0. gpio_c2p_en_o=0x00, irq_o=0.
- Write OUT=0xA5, OE=0x0F -> next cycle gpio_c2p_o=0xA5, gpio_c2p_en_o=0x0F. Write IN=0xFF -> IN still reflects pads.
- DEBTHR=0, p2c[0] 0->1 -> IN[0]=1 exactly 3 edges later. DEBTHR=4 -> 6 edges later. A 3-cycle pulse with DEBTHR=4 -> IN unchanged, PEND=0.
- RISE=0x01, IEN=0x01, p2c[0] rises -> PEND=0x01 on the commit edge, irq_o=1. Write PEND=0x01 -> PEND=0, irq_o=0. FALL=0 -> a later fall sets nothing.
- Hold the clear write to PEND=0x01 in the same cycle as a new rise commit -> PEND[0] stays 1.
- DEBTHR=200, p2c[3] high for 50 cycles, then write DEBTHR=10 -> IN[3] commits on the next edge. Assert rst_i mid-count -> all outputs 0 asynchronously.
